bcd_serial_adder_ctrl: RTL and testbench

Sequencer for multi-digit packed-BCD addition. It accepts two DIGITS-wide packed-BCD operands and a carry-in through a valid/ready handshake, then pushes one digit pair per cycle through a single shared BCD digit adder, least-significant digit first. It returns the packed-BCD sum and the final carry through a second valid/ready handshake. It lets wide decimal adds reuse one digit-adder datapath instead of a ripple of DIGITS copies.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_add.sv | 33 +++
 rtl/bcd_serial_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
// Provides the controller state encoding and the BCD digit constants
// used by both the one-digit adder and the sequencer.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ     = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder.
// Ports:
//   a, b  : input digits (4 bits each; values above 9 are tolerated)
//   c     : decimal carry in
//   digit : adjusted BCD result digit
//   carry : decimal carry out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   c,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   carry
);

    logic [5:0] t;
    logic [5:0] t_adj;

    // The 6-bit intermediate holds the worst case 15+15+1 (and +6 after
    // adjust) so out-of-range digits wrap predictably instead of overflowing.
    always_comb begin
        t     = {2'b00, a} + {2'b00, b} + {5'b00000, c};
        t_adj = t + {2'b00, BCD_ADJ};
        digit = t[3:0];
        carry = 1'b0;
        if (t > {2'b00, BCD_MAX}) begin
            digit = t_adj[3:0];
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Sequencer for multi-digit packed-BCD addition through one shared
// digit adder, least-significant digit first, one digit per cycle.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   start_valid, start_ready : operand handshake (ready only in IDLE)
//   a, b, cin                : packed-BCD operands and decimal carry in
//   res_valid, res_ready     : result handshake (valid only in DONE)
//   sum, cout, err           : packed-BCD sum, final carry, bad-digit flag
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]                   idx;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0] a_q;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0] b_q;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0] sum_q;
    logic                               carry;
    logic                               cout_q;
    logic                               err_q;

    logic [BCD_DIGIT_W-1:0] dig_a;
    logic [BCD_DIGIT_W-1:0] dig_b;
    logic [BCD_DIGIT_W-1:0] dig_sum;
    logic                   dig_carry;
    logic                   accept;
    logic                   last_digit;

    assign dig_a      = a_q[idx];
    assign dig_b      = b_q[idx];
    assign accept     = (state == IDLE) && start_valid;
    assign last_digit = (idx == IDX_LAST);

    bcd_digit_add u_digit_add (
        .a     (dig_a),
        .b     (dig_b),
        .c     (carry),
        .digit (dig_sum),
        .carry (dig_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, walk the digits in RUN, and wait
    // in DONE until the consumer takes the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_valid) state_next = RUN;
            RUN:  if (last_digit)  state_next = DONE;
            DONE: if (res_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then write one result digit per
    // RUN cycle. idx is returned to 0 on the last digit so non-power-of-two
    // DIGITS never leaves it pointing past the top digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum_q <= '0;
            err_q <= 1'b0;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_q[idx] <= dig_sum;
            carry      <= dig_carry;
            err_q      <= err_q | (dig_a > BCD_MAX) | (dig_b > BCD_MAX);
            if (last_digit) begin
                idx    <= '0;
                cout_q <= dig_carry;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl with DIGITS=4: directed
// cases, back-pressure, mid-run reset and randomized operations checked
// against a decimal-arithmetic reference model.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;

    int tests_run;
    int tests_failed;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .err         (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. Well-formed operands are added as plain decimal
    // integers; operands holding a digit above 9 fall back to the digit
    // rule (sum above 9 gets +6 and a carry).
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, output logic [W-1:0] ms,
                                  output logic mcout, output logic merr);
        int va, vb, tot, lim, t, c;
        logic [3:0] da, db;
        merr = 1'b0;
        ms   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (ma[4*k +: 4] > 4'd9 || mb[4*k +: 4] > 4'd9) merr = 1'b1;
        end
        if (!merr) begin
            va = 0; vb = 0; lim = 1;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                da = ma[4*k +: 4];
                db = mb[4*k +: 4];
                va = va * 10 + int'(da);
                vb = vb * 10 + int'(db);
                lim = lim * 10;
            end
            tot   = va + vb + int'(mcin);
            mcout = (tot >= lim);
            tot   = tot % lim;
            for (int k = 0; k < DIGITS; k++) begin
                ms[4*k +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mcin);
            for (int k = 0; k < DIGITS; k++) begin
                da = ma[4*k +: 4];
                db = mb[4*k +: 4];
                t  = int'(da) + int'(db) + c;
                if (t > 9) begin
                    ms[4*k +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    ms[4*k +: 4] = 4'(t);
                    c = 0;
                end
            end
            mcout = (c != 0);
        end
    endfunction

    // One comparison: counts it, and on mismatch counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer an operation and complete the start handshake; leaves the bench
    // #1 after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin);
        int n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("start_ready_wait", {31'd0, start_ready}, 32'd1);
        a = ta; b = tb; cin = tcin;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    // Wait for the result, checking latency in edges after the accept edge.
    task automatic waitResult(input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(DIGITS));
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] ta,
                               input logic [W-1:0] tb, input logic tcin);
        logic [W-1:0] es;
        logic         ec, ee;
        model(ta, tb, tcin, es, ec, ee);
        checkOutput({tag, "_sum"},  32'(sum),  32'(es));
        checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        checkOutput({tag, "_err"},  {31'd0, err},  {31'd0, ee});
    endtask

    task automatic takeResult(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
        checkOutput({tag, "_idle_valid"}, {31'd0, res_valid},   32'd0);
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tcin, input int hold);
        applyStimulus(ta, tb, tcin);
        waitResult(tag);
        checkResult(tag, ta, tb, tcin);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        takeResult(tag);
    endtask

    logic [W-1:0] ra, rb, ss;
    logic         rc, sc, se;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        res_ready    = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        checkOutput("rst_start_ready", {31'd0, start_ready}, 32'd1);
        checkOutput("rst_res_valid",   {31'd0, res_valid},   32'd0);
        checkOutput("rst_sum",         32'(sum),             32'd0);
        checkOutput("rst_cout",        {31'd0, cout},        32'd0);
        checkOutput("rst_err",         {31'd0, err},         32'd0);

        // Directed cases.
        runOp("d1234", 16'h1234, 16'h5678, 1'b0, 0);
        checkOutput("d1234_const", 32'(dut.sum), 32'h6912);
        runOp("ripple", 16'h9999, 16'h0001, 1'b0, 0);
        runOp("cinonly", 16'h0000, 16'h0000, 1'b1, 1);
        runOp("baddig", 16'h00A0, 16'h0000, 1'b0, 0);

        // Back-pressure: result must stay put while start is toggled.
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        waitResult("bp");
        ss = sum; sc = cout; se = err;
        for (int i = 0; i < 3; i++) begin
            start_valid = ~start_valid;
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_sum",   32'(sum), 32'h6912);
            checkOutput("bp_cout",  {31'd0, cout}, {31'd0, sc});
            checkOutput("bp_err",   {31'd0, err},  {31'd0, se});
            checkOutput("bp_valid", {31'd0, res_valid},   32'd1);
            checkOutput("bp_ready", {31'd0, start_ready}, 32'd0);
        end
        start_valid = 1'b0;
        takeResult("bp");
        @(posedge clk); #1;
        checkOutput("bp_no_accept", {31'd0, start_ready}, 32'd1);

        // Reset after digit 1 aborts the operation.
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_valid", {31'd0, res_valid},   32'd0);
        checkOutput("abort_sum",   32'(sum),             32'd0);
        checkOutput("abort_ready", {31'd0, start_ready}, 32'd1);
        runOp("after_abort", 16'h0005, 16'h0005, 1'b0, 0);

        // Randomized operations, mostly valid digits with occasional bad ones.
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < DIGITS; k++) begin
                ra[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
                rb[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            runOp("rand", ra, rb, rc, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
